calc_control: RTL and testbench
===============================

# calc_control

Calculator input sequencer between the `numpad` scanner and the arithmetic unit. It consumes one-cycle key events, builds two decimal operands, latches the operator, and issues a compute request to the ALU over a req/ack handshake. It then holds the result or error for the display.

## Interface
- `WIDTH`, default 16: operand/result width in bits; must be ≥ 14.
- `MAX_DIGITS`, default 4: maximum decimal digits per operand.

Ports:
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `key` in 5: `numpad` event. Bit 4 = valid; bits 3:0 = key index (column*4 + row). Valid for one clock per press.
- `op_a` out WIDTH: first operand to the ALU.
- `op_b` out WIDTH: second operand to the ALU.
- `op_code` out 2: operation to the ALU. 00 add, 01 sub, 10 mul, 11 div.
- `req` out 1: compute request.
- `ack` in 1: ALU completion. `result`/`err` are valid in the ack cycle.
- `result` in WIDTH: ALU result.
- `err` in 1: ALU error (div by zero, overflow, negative).
- `display` out WIDTH: value to show.
- `show_err` out 1: error indicator.
- `busy` out 1: high while `req` is high.

## Operation
Key map by index:
- Digits: 3→0, 0→1, 4→2, 8→3, 1→4, 5→5, 9→6, 2→7, 6→8, 10→9.
- Operators: 12(A)=add, 13(B)=sub, 14(C)=mul, 15(D)=div.
- 11(E)=equals, 7(F)=clear.
- Events with bit 4 = 0 are ignored.

Registers: A, B, cnt (digit count), op, pend_op, chain flag.

Digit append rule: if cnt < MAX_DIGITS, then acc ← acc*10 + d and cnt++; otherwise ignore the digit. The product is WIDTH bits; the digit limit guarantees no overflow.

State transitions:
- **ENTER_A**
  - digit: append to A.
  - op: latch op, go OP_WAIT.
  - E: ignored.
  - F: clear.
- **OP_WAIT**
  - digit: B=d, cnt=1, go ENTER_B.
  - op: replace op.
  - E: ignored.
  - F: clear.
- **ENTER_B**
  - digit: append to B.
  - E: chain=0, go EXEC.
  - op: pend_op=op key, chain=1, go EXEC.
  - F: clear.
- **EXEC**
  - `req`=1. All keys are ignored, including F.
  - On ack with err=1: go ERR.
  - On ack with err=0: A=result, cnt=0.
    - If chain=1: op=pend_op, go OP_WAIT.
    - Otherwise: go SHOW.
- **SHOW**
  - digit: A=d, cnt=1, go ENTER_A.
  - op: latch op, go OP_WAIT (the result becomes operand A).
  - E: ignored.
  - F: clear.
- **ERR**
  - Only F is accepted: clear.

Clear: A=B=0, cnt=0, op=00, chain=0, go ENTER_A.

`display` by state:
- ENTER_A, OP_WAIT, SHOW: A.
- ENTER_B, EXEC: B.
- ERR: 0.

`op_a`=A, `op_b`=B, `op_code`=op at all times.

## Timing
- Reset values: state ENTER_A; A=B=0; all outputs 0 (`req`, `busy`, `show_err`, `display`, `op_a`, `op_b`, `op_code`).
- A key event in cycle n updates registers and outputs in cycle n+1.
- `req` rises in the cycle after the E or chaining-op event.
- While `req`=1, `op_a`, `op_b` and `op_code` are stable.
- `req` is held until `ack`=1 is sampled, and falls in the next cycle. The request is never withdrawn except by reset.
- `ack` while `req`=0 is ignored.
- A key in the same cycle as `ack` is dropped.
- Reset at any point, including mid-EXEC, wins. `req` is 0 in the next cycle, and the ALU must tolerate the abandoned request.
- Minimum key-to-req latency is 1 cycle. The ALU latency is unbounded.

## Structure
- Package `calc_pkg`:
  - key index constants;
  - `op_t` encoding (add/sub/mul/div);
  - `state_t` enum (ENTER_A, OP_WAIT, ENTER_B, EXEC, SHOW, ERR);
  - the `KEY_VALID` bit position.
- Sub-module `key_decode` (combinational): maps `key` to {is_digit, digit[3:0], is_op, op[1:0], is_eq, is_clr}.
- `calc_control` holds the FSM, operand registers and handshake.

## Test plan
1. reset; keys 16,20,28,24,27 (1,2,A,3,E). Expect `req`=1 with `op_a`=12, `op_b`=3, `op_code`=00. ack with result=15 → `display`=15, `req`=0 the next cycle, state SHOW.
2. Keys 16,20,24,17,21 (1,2,3,4,5) with MAX_DIGITS=4 → `display`=1234. The 5th digit is ignored.
3. Keys 20,28,24,30,17,27 (2,A,3,C,4,E). First request a=2, b=3, op=00; ack result=5 → `display`=5, op=10. Key 4 → `display`=4. E → request a=5, b=4, op=10.
4. Keys 22,31,19,27 (8,D,0,E); ack with err=1 → `show_err`=1, `display`=0. Key 21 (5) is ignored. Key 23 (F) → `show_err`=0, `display`=0, state ENTER_A.
5. During EXEC, inject keys 21 and 23 and hold ack low for 10 cycles. Expect `req` to stay 1 with operands unchanged. A key coincident with ack is dropped. Reset mid-EXEC → `req`=0 and `display`=0 the next cycle.
6. Key values 5 and 12 (bit 4 = 0) → no change. Keys 18,28,29,20,27 (7,A,B,2,E) → request `op_code`=01, a=7, b=2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and key map for the calculator input sequencer.
package calc_pkg;

  localparam int KEY_VALID = 4;

  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;
  localparam logic [3:0] KEY_EQ  = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd7;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_op;
    op_t        op;
    logic       is_eq;
    logic       is_clr;
  } key_evt_t;

endpackage

// File: rtl/calc_control_if.sv
// Request/ack bus between the sequencer (master) and the arithmetic unit (slave).
interface calc_control_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_code;
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (output op_a, op_b, op_code, req, input ack, result, err);
  modport slave  (input op_a, op_b, op_code, req, output ack, result, err);
endinterface

// File: rtl/calc_control_key_decode.sv
// Combinational numpad event decoder: scanner index to digit/operator/equals/clear.
module key_decode
  import calc_pkg::*;
(
  input  logic [4:0] key,
  output key_evt_t   evt
);
  logic [3:0] idx;
  assign idx = key[3:0];

  always_comb begin
    evt = '0;
    if (key[KEY_VALID]) begin
      // digit layout follows the keypad wiring, not the index order
      case (idx)
        4'd3:  begin evt.is_digit = 1'b1; evt.digit = 4'd0; end
        4'd0:  begin evt.is_digit = 1'b1; evt.digit = 4'd1; end
        4'd4:  begin evt.is_digit = 1'b1; evt.digit = 4'd2; end
        4'd8:  begin evt.is_digit = 1'b1; evt.digit = 4'd3; end
        4'd1:  begin evt.is_digit = 1'b1; evt.digit = 4'd4; end
        4'd5:  begin evt.is_digit = 1'b1; evt.digit = 4'd5; end
        4'd9:  begin evt.is_digit = 1'b1; evt.digit = 4'd6; end
        4'd2:  begin evt.is_digit = 1'b1; evt.digit = 4'd7; end
        4'd6:  begin evt.is_digit = 1'b1; evt.digit = 4'd8; end
        4'd10: begin evt.is_digit = 1'b1; evt.digit = 4'd9; end
        KEY_ADD: begin evt.is_op = 1'b1; evt.op = OP_ADD; end
        KEY_SUB: begin evt.is_op = 1'b1; evt.op = OP_SUB; end
        KEY_MUL: begin evt.is_op = 1'b1; evt.op = OP_MUL; end
        KEY_DIV: begin evt.is_op = 1'b1; evt.op = OP_DIV; end
        KEY_EQ:  evt.is_eq  = 1'b1;
        KEY_CLR: evt.is_clr = 1'b1;
        default: evt = '0;
      endcase
    end
  end
endmodule

// File: rtl/calc_control.sv
// Calculator sequencer: builds two decimal operands, latches the operator and
// runs a req/ack exchange with the ALU, then holds the result or error.
module calc_control
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key,
  calc_control_if.master   alu,
  output logic [WIDTH-1:0] display,
  output logic             show_err,
  output logic             busy
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d, pend_q, pend_d;
  logic             chain_q, chain_d;
  logic             do_clr;
  key_evt_t         evt;
  logic [WIDTH-1:0] digit_w, a_app, b_app;
  logic             can_app;

  key_decode u_dec (.key(key), .evt(evt));

  // digit limit keeps acc*10+d inside WIDTH bits
  assign digit_w = WIDTH'(evt.digit);
  assign can_app = cnt_q < CNT_W'(MAX_DIGITS);
  assign a_app   = a_q * WIDTH'(10) + digit_w;
  assign b_app   = b_q * WIDTH'(10) + digit_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      pend_q  <= OP_ADD;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      chain_q <= chain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pend_d  = pend_q;
    chain_d = chain_q;
    do_clr  = 1'b0;
    case (state_q)
      ENTER_A: begin
        do_clr = evt.is_clr;
        if (evt.is_digit && can_app) begin
          a_d   = a_app;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (evt.is_op) begin
          op_d    = evt.op;
          state_d = OP_WAIT;
        end
      end
      OP_WAIT: begin
        do_clr = evt.is_clr;
        if (evt.is_digit) begin
          b_d     = digit_w;
          cnt_d   = CNT_W'(1);
          state_d = ENTER_B;
        end else if (evt.is_op) begin
          op_d = evt.op;
        end
      end
      ENTER_B: begin
        do_clr = evt.is_clr;
        if (evt.is_digit && can_app) begin
          b_d   = b_app;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (evt.is_eq) begin
          chain_d = 1'b0;
          state_d = EXEC;
        end else if (evt.is_op) begin
          pend_d  = evt.op;
          chain_d = 1'b1;
          state_d = EXEC;
        end
      end
      // keys, clear included, are dropped until the ALU answers
      EXEC: begin
        if (alu.ack) begin
          if (alu.err) begin
            state_d = ERR;
          end else begin
            a_d   = alu.result;
            cnt_d = '0;
            if (chain_q) begin
              op_d    = pend_q;
              state_d = OP_WAIT;
            end else begin
              state_d = SHOW;
            end
          end
        end
      end
      SHOW: begin
        do_clr = evt.is_clr;
        if (evt.is_digit) begin
          a_d     = digit_w;
          cnt_d   = CNT_W'(1);
          state_d = ENTER_A;
        end else if (evt.is_op) begin
          op_d    = evt.op;
          state_d = OP_WAIT;
        end
      end
      ERR:     do_clr = evt.is_clr;
      default: state_d = ENTER_A;
    endcase
    if (do_clr) begin
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      op_d    = OP_ADD;
      chain_d = 1'b0;
      state_d = ENTER_A;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_B, EXEC: display = b_q;
      ERR:           display = '0;
      default:       display = a_q;
    endcase
  end

  assign show_err    = (state_q == ERR);
  assign busy        = (state_q == EXEC);
  assign alu.req     = (state_q == EXEC);
  assign alu.op_a    = a_q;
  assign alu.op_b    = b_q;
  assign alu.op_code = op_q;
endmodule

// File: tb/tb_calc_control.sv
// Randomized and directed bench for calc_control against a behavioural calculator model.
module tb_calc_control;
  localparam int W = 16;
  localparam int MAXD = 4;
  localparam int P_EA = 0, P_OW = 1, P_EB = 2, P_EX = 3, P_SH = 4, P_ER = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic [4:0]   key;
  logic [W-1:0] display;
  logic         show_err, busy;

  calc_control_if #(.WIDTH(W)) alu ();

  calc_control #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .clock(clock), .reset(reset), .key(key), .alu(alu),
    .display(display), .show_err(show_err), .busy(busy)
  );

  always #10 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // calculator model: phase plus the numbers a user would see
  int dig_tab [16] = '{1, 4, 7, 0, 2, 5, 8, -1, 3, 6, 9, -1, -1, -1, -1, -1};
  int m_phase, m_a, m_b, m_cnt, m_op, m_pend;
  bit m_chain;

  function automatic void m_clear();
    m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_chain = 0; m_phase = P_EA;
  endfunction

  function automatic void m_update(input logic [4:0] k, input bit a, input int res,
                                   input bit e, input bit rst);
    int idx, d, opv;
    bit isop, iseq;
    if (rst) begin m_clear(); return; end
    if (m_phase == P_EX) begin
      if (a) begin
        if (e) m_phase = P_ER;
        else begin
          m_a = res; m_cnt = 0;
          if (m_chain) begin m_op = m_pend; m_phase = P_OW; end
          else m_phase = P_SH;
        end
      end
      return;
    end
    if (!k[4]) return;
    idx = int'(k[3:0]);
    d = dig_tab[idx];
    isop = idx >= 12;
    opv = idx - 12;
    iseq = idx == 11;
    if (idx == 7) begin m_clear(); return; end
    case (m_phase)
      P_EA: if (d >= 0) begin
              if (m_cnt < MAXD) begin m_a = m_a * 10 + d; m_cnt++; end
            end else if (isop) begin m_op = opv; m_phase = P_OW; end
      P_OW: if (d >= 0) begin m_b = d; m_cnt = 1; m_phase = P_EB; end
            else if (isop) m_op = opv;
      P_EB: if (d >= 0) begin
              if (m_cnt < MAXD) begin m_b = m_b * 10 + d; m_cnt++; end
            end else if (iseq) begin m_chain = 0; m_phase = P_EX; end
            else if (isop) begin m_pend = opv; m_chain = 1; m_phase = P_EX; end
      P_SH: if (d >= 0) begin m_a = d; m_cnt = 1; m_phase = P_EA; end
            else if (isop) begin m_op = opv; m_phase = P_OW; end
      default: ;
    endcase
  endfunction

  function automatic int exp_display();
    if (m_phase == P_EB || m_phase == P_EX) return m_b;
    if (m_phase == P_ER) return 0;
    return m_a;
  endfunction

  // ideal ALU: plain integer math, error on negative, overflow or divide by zero
  function automatic void alu_calc(input int a, input int b, input int op,
                                   output int r, output bit e);
    longint s;
    s = 0; e = 0;
    case (op)
      0: s = longint'(a) + b;
      1: s = longint'(a) - b;
      2: s = longint'(a) * b;
      default: if (b == 0) e = 1; else s = a / b;
    endcase
    if (s < 0 || s > 65535) e = 1;
    r = e ? 0 : int'(s);
  endfunction

  task automatic step(input logic [4:0] k, input bit a, input int res, input bit e, input bit rst);
    key = k; alu.ack = a; alu.result = W'(res); alu.err = e; reset = rst;
    @(posedge clock);
    m_update(k, a, res, e, rst);
    #1;
    key = '0; alu.ack = 1'b0; alu.result = '0; alu.err = 1'b0; reset = 1'b0;
  endtask

  task automatic keys(input int n, input logic [4:0] k0, input logic [4:0] k1, input logic [4:0] k2,
                      input logic [4:0] k3, input logic [4:0] k4, input logic [4:0] k5);
    logic [4:0] ks [6];
    ks = '{k0, k1, k2, k3, k4, k5};
    for (int i = 0; i < n; i++) step(ks[i], 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(5'd16, 0, 0, 0, 1);
    step(5'd0, 0, 0, 0, 1);
    n_chk++; if (display !== '0) begin n_fail++; $display("FAIL reset_display: got %0d want 0", display); end
    n_chk++; if ({alu.req, busy, show_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {alu.req, busy, show_err}); end
    n_chk++; if ({alu.op_a, alu.op_b, alu.op_code} !== '0) begin n_fail++; $display("FAIL reset_ops: got a=%0d b=%0d op=%0d want 0", alu.op_a, alu.op_b, alu.op_code); end
  endtask

  task automatic test_basic();
    step(0, 0, 0, 0, 1);
    keys(5, 5'd16, 5'd20, 5'd28, 5'd24, 5'd27, 0);
    n_chk++; if ({alu.req, busy} !== 2'b11) begin n_fail++; $display("FAIL basic_req: got %b want 11", {alu.req, busy}); end
    n_chk++; if (alu.op_a !== 16'd12 || alu.op_b !== 16'd3 || alu.op_code !== 2'd0) begin n_fail++; $display("FAIL basic_ops: got a=%0d b=%0d op=%0d want 12 3 0", alu.op_a, alu.op_b, alu.op_code); end
    step(0, 1, 15, 0, 0);
    n_chk++; if (display !== 16'd15 || alu.req !== 1'b0) begin n_fail++; $display("FAIL basic_result: got disp=%0d req=%b want 15 0", display, alu.req); end
    step(5'd21, 0, 0, 0, 0);
    n_chk++; if (display !== 16'd5) begin n_fail++; $display("FAIL basic_show_digit: got %0d want 5", display); end
  endtask

  task automatic test_digit_limit();
    step(0, 0, 0, 0, 1);
    keys(5, 5'd16, 5'd20, 5'd24, 5'd17, 5'd21, 0);
    n_chk++; if (display !== 16'd1234) begin n_fail++; $display("FAIL digit_limit: got %0d want 1234", display); end
  endtask

  task automatic test_chain();
    step(0, 0, 0, 0, 1);
    keys(4, 5'd20, 5'd28, 5'd24, 5'd30, 0, 0);
    n_chk++; if (alu.req !== 1'b1 || alu.op_a !== 16'd2 || alu.op_b !== 16'd3 || alu.op_code !== 2'd0) begin n_fail++; $display("FAIL chain_req1: got req=%b a=%0d b=%0d op=%0d want 1 2 3 0", alu.req, alu.op_a, alu.op_b, alu.op_code); end
    step(0, 1, 5, 0, 0);
    n_chk++; if (display !== 16'd5 || alu.op_code !== 2'd2 || alu.req !== 1'b0) begin n_fail++; $display("FAIL chain_ack: got disp=%0d op=%0d req=%b want 5 2 0", display, alu.op_code, alu.req); end
    step(5'd17, 0, 0, 0, 0);
    n_chk++; if (display !== 16'd4) begin n_fail++; $display("FAIL chain_b: got %0d want 4", display); end
    step(5'd27, 0, 0, 0, 0);
    n_chk++; if (alu.req !== 1'b1 || alu.op_a !== 16'd5 || alu.op_b !== 16'd4 || alu.op_code !== 2'd2) begin n_fail++; $display("FAIL chain_req2: got req=%b a=%0d b=%0d op=%0d want 1 5 4 2", alu.req, alu.op_a, alu.op_b, alu.op_code); end
    step(0, 1, 20, 0, 0);
  endtask

  task automatic test_error();
    step(0, 0, 0, 0, 1);
    keys(4, 5'd22, 5'd31, 5'd19, 5'd27, 0, 0);
    step(0, 1, 0, 1, 0);
    n_chk++; if (show_err !== 1'b1 || display !== '0 || alu.req !== 1'b0) begin n_fail++; $display("FAIL err_enter: got err=%b disp=%0d req=%b want 1 0 0", show_err, display, alu.req); end
    step(5'd21, 0, 0, 0, 0);
    n_chk++; if (show_err !== 1'b1 || display !== '0) begin n_fail++; $display("FAIL err_digit: got err=%b disp=%0d want 1 0", show_err, display); end
    step(5'd23, 0, 0, 0, 0);
    n_chk++; if (show_err !== 1'b0 || display !== '0) begin n_fail++; $display("FAIL err_clear: got err=%b disp=%0d want 0 0", show_err, display); end
    step(5'd16, 0, 0, 0, 0);
    n_chk++; if (display !== 16'd1) begin n_fail++; $display("FAIL err_enter_a: got %0d want 1", display); end
  endtask

  task automatic test_exec_hold();
    step(0, 0, 0, 0, 1);
    keys(6, 5'd16, 5'd28, 5'd20, 5'd27, 5'd21, 5'd23);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      n_chk++; if (alu.req !== 1'b1 || alu.op_a !== 16'd1 || alu.op_b !== 16'd2 || alu.op_code !== 2'd0) begin n_fail++; $display("FAIL hold_%0d: got req=%b a=%0d b=%0d op=%0d want 1 1 2 0", i, alu.req, alu.op_a, alu.op_b, alu.op_code); end
    end
    step(5'd21, 1, 3, 0, 0);
    n_chk++; if (display !== 16'd3 || alu.req !== 1'b0) begin n_fail++; $display("FAIL hold_key_with_ack: got disp=%0d req=%b want 3 0", display, alu.req); end
    keys(4, 5'd27, 5'd28, 5'd16, 5'd27, 0, 0);
    n_chk++; if (alu.req !== 1'b1 || alu.op_a !== 16'd3 || alu.op_b !== 16'd1) begin n_fail++; $display("FAIL hold_req2: got req=%b a=%0d b=%0d want 1 3 1", alu.req, alu.op_a, alu.op_b); end
    step(0, 0, 0, 0, 1);
    n_chk++; if (alu.req !== 1'b0 || display !== '0 || alu.op_a !== '0) begin n_fail++; $display("FAIL hold_reset: got req=%b disp=%0d a=%0d want 0 0 0", alu.req, display, alu.op_a); end
  endtask

  task automatic test_invalid_keys();
    step(0, 0, 0, 0, 1);
    step(0, 1, 99, 0, 0);
    n_chk++; if (display !== '0 || alu.req !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got disp=%0d req=%b want 0 0", display, alu.req); end
    keys(3, 5'd5, 5'd12, 5'd18, 0, 0, 0);
    keys(2, 5'd5, 5'd12, 0, 0, 0, 0);
    n_chk++; if (display !== 16'd7 || alu.op_code !== 2'd0) begin n_fail++; $display("FAIL invalid_ignored: got disp=%0d op=%0d want 7 0", display, alu.op_code); end
    keys(4, 5'd28, 5'd29, 5'd20, 5'd27, 0, 0);
    n_chk++; if (alu.req !== 1'b1 || alu.op_code !== 2'd1 || alu.op_a !== 16'd7 || alu.op_b !== 16'd2) begin n_fail++; $display("FAIL op_replace: got req=%b op=%0d a=%0d b=%0d want 1 1 7 2", alu.req, alu.op_code, alu.op_a, alu.op_b); end
    step(0, 1, 5, 0, 0);
  endtask

  task automatic test_random();
    int r, pick, exp_d;
    bit e;
    logic [4:0] k;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 60) k = {1'b1, 4'($urandom_range(0, 10))};
      else if (pick < 75) k = {1'b1, 4'($urandom_range(12, 15))};
      else if (pick < 87) k = 5'd27;
      else if (pick < 90) k = 5'd23;
      else k = 5'($urandom);
      if (m_phase == P_EX && $urandom_range(0, 2) == 0) begin
        alu_calc(m_a, m_b, m_op, r, e);
        step(k, 1, r, e, 0);
      end else begin
        step(k, 0, 0, 0, $urandom_range(0, 199) == 0);
      end
      exp_d = exp_display();
      n_chk++; if (display !== W'(exp_d)) begin n_fail++; $display("FAIL rand_display @%0d: got %0d want %0d", i, display, exp_d); end
      n_chk++; if ({alu.req, busy, show_err} !== {m_phase == P_EX, m_phase == P_EX, m_phase == P_ER}) begin n_fail++; $display("FAIL rand_flags @%0d: got %b phase %0d", i, {alu.req, busy, show_err}, m_phase); end
      n_chk++; if (alu.op_a !== W'(m_a) || alu.op_b !== W'(m_b) || alu.op_code !== 2'(m_op)) begin n_fail++; $display("FAIL rand_ops @%0d: got a=%0d b=%0d op=%0d want %0d %0d %0d", i, alu.op_a, alu.op_b, alu.op_code, m_a, m_b, m_op); end
    end
  endtask

  initial begin
    key = '0; reset = 1'b1; alu.ack = 1'b0; alu.result = '0; alu.err = 1'b0;
    m_pend = 0;
    m_clear();
    test_reset();
    test_basic();
    test_digit_limit();
    test_chain();
    test_error();
    test_exec_hold();
    test_invalid_keys();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
